// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_loader
// Description : Debounced three-press loader for the ALU a/b/op operands.
//               Presses load A, then B, then the opcode; reloads of the
//               opcode are accepted while running.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_loader #(
    parameter int DATA_W          = 4,
    parameter int OP_W            = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_load,
    input  logic              btn_clear,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [OP_W-1:0]   op,
    output logic              valid,
    output logic              load_pulse,
    output logic [1:0]        state
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RUN = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_sw_meta;
    logic [DATA_W-1:0]   r_sw_sync;
    logic [1:0]          r_btn_meta;      // [0] load, [1] clear
    logic [1:0]          r_btn_sync;
    logic [c_CNT_W-1:0]  r_db_cnt [2];
    logic [1:0]          r_db_stable;
    logic [1:0]          r_db_stable_q;
    logic                w_press_load;
    logic                w_press_clr;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [OP_W-1:0]     r_op;
    logic                r_valid;
    logic                r_load_pulse;
    logic [DATA_W-1:0]   w_a_nxt;
    logic [DATA_W-1:0]   w_b_nxt;
    logic [OP_W-1:0]     w_op_nxt;
    logic                w_valid_nxt;
    logic                w_pulse_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            r_sw_meta  <= sw;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= {btn_clear, btn_load};
            r_btn_sync <= r_btn_meta;
        end
    end

    // A button's stable level only follows the synced level after it has
    // differed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
            r_db_stable   <= '0;
            r_db_stable_q <= '0;
        end else begin
            r_db_stable_q <= r_db_stable;
            for (int i = 0; i < 2; i++) begin
                if (r_btn_sync[i] == r_db_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == c_CNT_MAX) begin
                    r_db_stable[i] <= r_btn_sync[i];
                    r_db_cnt[i]    <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + c_CNT_W'(1);
                end
            end
        end
    end

    assign w_press_load = r_db_stable[0] & ~r_db_stable_q[0];
    assign w_press_clr  = r_db_stable[1] & ~r_db_stable_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear takes priority over a load arriving in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_op_nxt    = r_op;
        w_valid_nxt = r_valid;
        w_pulse_nxt = 1'b0;
        if (w_press_clr) begin
            w_state_nxt = S_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_op_nxt    = '0;
            w_valid_nxt = 1'b0;
        end else if (w_press_load) begin
            case (r_state)
                S_A: begin
                    w_a_nxt     = r_sw_sync;
                    w_state_nxt = S_B;
                end
                S_B: begin
                    w_b_nxt     = r_sw_sync;
                    w_state_nxt = S_OP;
                end
                S_OP: begin
                    w_op_nxt    = r_sw_sync[OP_W-1:0];
                    w_valid_nxt = 1'b1;
                    w_pulse_nxt = 1'b1;
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    w_op_nxt    = r_sw_sync[OP_W-1:0];
                    w_pulse_nxt = 1'b1;
                end
                default: w_state_nxt = S_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_valid      <= 1'b0;
            r_load_pulse <= 1'b0;
        end else begin
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_op         <= w_op_nxt;
            r_valid      <= w_valid_nxt;
            r_load_pulse <= w_pulse_nxt;
        end
    end

    assign a          = r_a;
    assign b          = r_b;
    assign op         = r_op;
    assign valid      = r_valid;
    assign load_pulse = r_load_pulse;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_loader
// Description : Directed bench for alu_operand_loader with a sample-window
//               reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_loader;

    localparam int DW = 4;
    localparam int OW = 3;
    localparam int DB = 4;

    logic          clk;
    logic          clk_en;
    logic          rst_n;
    logic [DW-1:0] sw;
    logic          btn_load;
    logic          btn_clear;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
    logic          valid;
    logic          load_pulse;
    logic [1:0]    state;

    int vectors;
    int miscompares;
    int pulse_seen;

    alu_operand_loader #(
        .DATA_W          (DW),
        .OP_W            (OW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .btn_load   (btn_load),
        .btn_clear  (btn_clear),
        .a          (a),
        .b          (b),
        .op         (op),
        .valid      (valid),
        .load_pulse (load_pulse),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    // Reference model: raw inputs seen at every edge; a button level flips
    // once the DB samples that reached the synchronizer output all disagree.
    typedef struct packed {
        logic          ld;
        logic          clr;
        logic [DW-1:0] sw;
    } samp_t;

    samp_t         hist[$];
    logic [1:0]    m_stable;
    logic [1:0]    m_rise;
    logic [DW-1:0] e_a;
    logic [DW-1:0] e_b;
    logic [OW-1:0] e_op;
    logic          e_valid;
    logic          e_pulse;
    logic [1:0]    e_state;

    function automatic samp_t at(input int idx);
        if (idx < 0) return '0;
        return hist[idx];
    endfunction

    task automatic m_reset();
        hist.delete();
        m_stable = '0;
        m_rise   = '0;
        e_a = '0; e_b = '0; e_op = '0;
        e_valid = 1'b0; e_pulse = 1'b0; e_state = 2'd0;
    endtask

    task automatic m_step();
        samp_t         s;
        int            n;
        logic [DW-1:0] sw_used;
        logic          all_diff;
        logic          lvl;
        s.ld = btn_load; s.clr = btn_clear; s.sw = sw;
        hist.push_back(s);
        n = hist.size();
        e_pulse = 1'b0;
        if (m_rise[1]) begin
            e_a = '0; e_b = '0; e_op = '0; e_valid = 1'b0; e_state = 2'd0;
        end else if (m_rise[0]) begin
            sw_used = at(n - 3).sw;
            case (e_state)
                2'd0: begin e_a = sw_used; e_state = 2'd1; end
                2'd1: begin e_b = sw_used; e_state = 2'd2; end
                2'd2: begin e_op = sw_used[OW-1:0]; e_valid = 1'b1; e_pulse = 1'b1; e_state = 2'd3; end
                default: begin e_op = sw_used[OW-1:0]; e_pulse = 1'b1; end
            endcase
        end
        for (int k = 0; k < 2; k++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) begin
                lvl = (k == 1) ? at(n - 3 - j).clr : at(n - 3 - j).ld;
                if (lvl == m_stable[k]) all_diff = 1'b0;
            end
            m_rise[k] = 1'b0;
            if (all_diff) begin
                m_stable[k] = ~m_stable[k];
                m_rise[k]   = m_stable[k];
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial begin
        logic [14:0] got;
        logic [14:0] exp;
        forever begin
            @(negedge clk);
            got = {a, b, op, valid, load_pulse, state};
            exp = {e_a, e_b, e_op, e_valid, e_pulse, e_state};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t: a,b,op,valid,pulse,state got %b required %b",
                         $time, got, exp);
            end
        end
    end

    initial begin
        pulse_seen = 0;
        forever begin
            @(negedge clk);
            if (load_pulse === 1'b1) pulse_seen++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [DW-1:0] v);
        @(negedge clk);
        sw       = v;
        btn_load = 1'b1;
        idle(10);
        btn_load = 1'b0;
        idle(10);
        #1;
    endtask

    initial begin
        int p0;
        vectors     = 0;
        miscompares = 0;
        clk_en    = 1'b0;
        rst_n     = 1'b1;
        sw        = '0;
        btn_load  = 1'b0;
        btn_clear = 1'b0;

        // 1: reset with no clock running
        #5 rst_n = 1'b0;
        #2;
        check("rst_a", 32'(a), 32'h0);
        check("rst_b", 32'(b), 32'h0);
        check("rst_op", 32'(op), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_pulse", 32'(load_pulse), 32'h0);
        check("rst_state", 32'(state), 32'h0);
        #3 rst_n = 1'b1;
        #5 clk_en = 1'b1;
        idle(4);

        // 3: short glitches ignored, long hold loads A exactly once
        sw = 4'hF;
        repeat (5) begin
            @(negedge clk) btn_load = 1'b1;
            @(negedge clk);
            @(negedge clk) btn_load = 1'b0;
            idle(3);
        end
        #1;
        check("glitch_state", 32'(state), 32'h0);
        check("glitch_a", 32'(a), 32'h0);
        @(negedge clk);
        sw       = 4'b1001;
        btn_load = 1'b1;
        idle(20);
        btn_load = 1'b0;
        idle(10);
        #1;
        check("hold_state", 32'(state), 32'h1);
        check("hold_a", 32'(a), 32'h9);

        // 2: complete the operation
        press(4'b1011);
        check("b_load", 32'(b), 32'hB);
        check("b_state", 32'(state), 32'h2);
        p0 = pulse_seen;
        press(4'b0001);
        check("op_load", 32'(op), 32'h1);
        check("op_valid", 32'(valid), 32'h1);
        check("op_state", 32'(state), 32'h3);
        check("op_pulses", 32'(pulse_seen - p0), 32'h1);

        // 4: opcode reload while running
        p0 = pulse_seen;
        press(4'b0111);
        check("reload_op", 32'(op), 32'h7);
        check("reload_a", 32'(a), 32'h9);
        check("reload_b", 32'(b), 32'hB);
        check("reload_pulses", 32'(pulse_seen - p0), 32'h1);

        // clear back to S_A
        @(negedge clk) btn_clear = 1'b1;
        idle(10);
        btn_clear = 1'b0;
        idle(10);
        #1;
        check("clr_state", 32'(state), 32'h0);
        check("clr_valid", 32'(valid), 32'h0);

        // 6: asynchronous reset mid-operation
        press(4'b1001);
        press(4'b1011);
        check("pre_rst_state", 32'(state), 32'h2);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_outputs", 32'({a, b, op, valid, load_pulse, state}), 32'h0);
        idle(3);
        #2 rst_n = 1'b1;
        idle(3);
        press(4'b0101);
        check("post_rst_a", 32'(a), 32'h5);
        check("post_rst_state", 32'(state), 32'h1);

        // 5: simultaneous clear and load in S_B, clear wins
        @(negedge clk);
        sw        = 4'b0011;
        btn_load  = 1'b1;
        btn_clear = 1'b1;
        idle(10);
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        idle(10);
        #1;
        check("both_state", 32'(state), 32'h0);
        check("both_valid", 32'(valid), 32'h0);
        check("both_a", 32'(a), 32'h0);
        check("both_b", 32'(b), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
